// File: rtl/i2c_tx_if.sv
// Bus and byte-handshake signals for the i2c_tx open-drain byte transmitter.
interface i2c_tx_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       abort;
  logic       busy;
  logic       ack_valid;
  logic       nack;

  modport master (
    output scl, sda_in, data, data_valid, abort,
    input  sda_oe, data_ready, busy, ack_valid, nack
  );

  modport slave (
    input  scl, sda_in, data, data_valid, abort,
    output sda_oe, data_ready, busy, ack_valid, nack
  );
endinterface

// File: rtl/i2c_tx.sv
// I2C byte transmitter: shifts a byte MSB-first onto SDA in step with an external
// SCL, then samples the receiver's ack bit on the 9th clock.
module i2c_tx #(
  parameter int HOLD_CYCLES = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic     clk,
  input logic     rstn,
  i2c_tx_if.slave bus
);
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_LOW, HOLD, DATA, ACK_HOLD, ACK} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_prev, scl_rise, scl_fall;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   last_q, last_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   ack_valid_q, ack_valid_d;
  logic                   nack_q, nack_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev <= scl_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      last_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      ack_valid_q <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      sda_oe_q    <= sda_oe_d;
      ack_valid_q <= ack_valid_d;
      nack_q      <= nack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    last_d      = last_q;
    sda_oe_d    = sda_oe_q;
    ack_valid_d = 1'b0;
    nack_d      = nack_q;
    if (bus.abort) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      hold_d   = '0;
      last_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
          if (bus.data_valid) begin
            shift_d   = bus.data;
            bit_cnt_d = 3'd7;
            last_d    = 1'b0;
            hold_d    = '0;
            state_d   = WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!scl_s) begin
            hold_d  = '0;
            state_d = HOLD;
          end
        end
        // Both hold phases share the counter; a rising SCL before expiry means
        // the master clocked faster than SDA could settle, so drop the byte.
        HOLD, ACK_HOLD: begin
          if (scl_rise) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            hold_d   = '0;
            last_d   = 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (state_q == HOLD) begin
              sda_oe_d = ~shift_q[7];
              state_d  = DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ACK;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        // bit_cnt parks at 0; last marks that the 8th bit has been clocked out.
        DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_cnt_q == 3'd0) last_d = 1'b1;
            else                   bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (scl_fall) begin
            state_d = last_q ? ACK_HOLD : HOLD;
          end
        end
        ACK: begin
          if (scl_rise) begin
            ack_valid_d = 1'b1;
            nack_d      = sda_s;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.data_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.ack_valid  = ack_valid_q;
  assign bus.nack       = nack_q;
endmodule

// File: tb/tb_i2c_tx.sv
// Scoreboard bench for i2c_tx: a bit-banged SCL master and ack responder drive the
// bus; monitors reassemble SDA bytes and ack results against queued expectations.
module tb_i2c_tx;
  localparam int HOLD   = 4;
  localparam int LOW_T  = 20;
  localparam int HIGH_T = 20;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic scl_m = 1'b1;
  logic rx_pull = 1'b0;
  logic sda_line;

  i2c_tx_if bus();

  i2c_tx #(.HOLD_CYCLES(HOLD), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign sda_line   = ~bus.sda_oe & ~rx_pull;
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_line;

  logic [7:0] exp_byte_q[$];
  logic       exp_nack_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         capture = 1'b0;
  int         bit_idx = 0;
  logic [7:0] got = '0;
  logic       hi_level = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reassemble the byte seen on SDA at each SCL rise.
  initial forever begin
    @(posedge scl_m);
    hi_level = sda_line;
    if (capture) begin
      if (bit_idx < 8) got = {got[6:0], sda_line};
      bit_idx++;
      if (bit_idx == 8) begin
        if (exp_byte_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte_unexpected: got %02h required none", got);
        end else begin
          check("tx_byte", got, exp_byte_q.pop_front());
        end
      end
      if (bit_idx == 9) bit_idx = 0;
    end
  end

  initial forever begin
    @(negedge scl_m);
    if (capture && bit_idx != 0) check("sda_stable_high", sda_line, hi_level);
  end

  initial forever begin
    @(negedge clk);
    if (bus.ack_valid) begin
      if (exp_nack_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ack_unexpected: ack_valid=1 required 0");
      end else begin
        check("nack", bus.nack, exp_nack_q.pop_front());
      end
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic scl_clocks(input int n, input logic [31:0] pull_mask);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      rx_pull = pull_mask[i];
      cyc(LOW_T - 1);
      scl_m = 1'b1;
      cyc(HIGH_T);
      scl_m = 1'b0;
    end
    cyc(1);
    rx_pull = 1'b0;
  endtask

  task automatic offer(input logic [7:0] b, output bit ok);
    bus.data = b;
    bus.data_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.data_ready) begin
        cyc(1);
        ok = 1'b1;
      end else begin
        cyc(1);
      end
    end
    bus.data_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: data_ready=0 required 1");
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_pull);
    bit ok;
    scl_m = 1'b0;
    offer(b, ok);
    if (ok) begin
      exp_byte_q.push_back(b);
      exp_nack_q.push_back(!ack_pull);
      bit_idx = 0;
      capture = 1'b1;
      scl_clocks(9, {23'b0, ack_pull, 8'b0});
      cyc(4);
      check("idle_after_ack", bus.busy, 1'b0);
    end
  endtask

  initial begin
    bit ok;
    bus.data = '0;
    bus.data_valid = 1'b0;
    bus.abort = 1'b0;
    cyc(3);
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ack_valid", bus.ack_valid, 1'b0);
    check("rst_nack", bus.nack, 1'b0);
    rstn = 1'b1;
    cyc(2);
    check("rst_ready", bus.data_ready, 1'b1);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b0);

    // Second byte offered exactly in the IDLE cycle carrying ack_valid.
    scl_m = 1'b0;
    offer(8'h3C, ok);
    if (ok) begin
      exp_byte_q.push_back(8'h3C);
      exp_nack_q.push_back(1'b0);
      bit_idx = 0;
      capture = 1'b1;
      fork
        scl_clocks(18, 32'h0002_0100);
        begin
          bit seen = 1'b0;
          for (int i = 0; i < 1000 && !seen; i++) begin
            cyc(1);
            seen = bus.ack_valid;
          end
          if (!seen) begin
            checks++;
            failures++;
            $display("FAIL b2b_ack_timeout: ack_valid=0 required 1");
          end else begin
            check("b2b_ready", bus.data_ready, 1'b1);
            bus.data = 8'hFF;
            bus.data_valid = 1'b1;
            exp_byte_q.push_back(8'hFF);
            exp_nack_q.push_back(1'b0);
            cyc(1);
            bus.data_valid = 1'b0;
            check("b2b_accepted", bus.busy, 1'b1);
          end
        end
      join
      cyc(4);
      check("b2b_idle", bus.busy, 1'b0);
    end

    // Byte offered while busy must be ignored.
    fork
      send_byte(8'h81, 1'b1);
      begin
        repeat (2) @(posedge scl_m);
        #1;
        check("ready_while_busy", bus.data_ready, 1'b0);
        bus.data = 8'h55;
        bus.data_valid = 1'b1;
        repeat (3) @(posedge scl_m);
        #1;
        bus.data_valid = 1'b0;
      end
    join

    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      logic       a;
      b = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      send_byte(b, a);
    end

    // Reset mid-byte releases SDA asynchronously.
    capture = 1'b0;
    scl_m = 1'b0;
    offer(8'h00, ok);
    scl_clocks(3, 32'h0);
    begin
      int n = 0;
      while (!bus.sda_oe && n < 100) begin
        cyc(1);
        n++;
      end
    end
    check("oe_before_reset", bus.sda_oe, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("reset_async_oe", bus.sda_oe, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    cyc(2);
    rstn = 1'b1;
    cyc(2);
    check("reset_nack", bus.nack, 1'b0);
    send_byte(8'hC3, 1'b1);

    // Abort while holding the last data bit before the ack clock.
    capture = 1'b0;
    scl_m = 1'b0;
    offer(8'hF0, ok);
    scl_clocks(7, 32'h0);
    cyc(LOW_T);
    scl_m = 1'b1;
    cyc(HIGH_T);
    scl_m = 1'b0;
    cyc(4);
    check("ackhold_busy", bus.busy, 1'b1);
    check("ackhold_oe", bus.sda_oe, 1'b1);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    check("abort_oe", bus.sda_oe, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    cyc(LOW_T);
    scl_m = 1'b1;
    cyc(HIGH_T);
    scl_m = 1'b0;
    cyc(4);
    check("abort_still_idle", bus.busy, 1'b0);

    // SCL rises one cycle after a fall, inside the hold window.
    scl_m = 1'b0;
    offer(8'h00, ok);
    scl_clocks(2, 32'h0);
    cyc(LOW_T);
    scl_m = 1'b1;
    cyc(HIGH_T);
    scl_m = 1'b0;
    cyc(1);
    check("err_pre_oe", bus.sda_oe, 1'b1);
    scl_m = 1'b1;
    cyc(3);
    check("err_oe", bus.sda_oe, 1'b0);
    check("err_busy", bus.busy, 1'b0);
    cyc(HIGH_T);
    scl_m = 1'b0;
    cyc(LOW_T);
    scl_m = 1'b1;
    cyc(HIGH_T);
    scl_m = 1'b0;
    cyc(4);
    check("err_still_idle", bus.busy, 1'b0);

    send_byte(8'h5A, 1'b0);

    cyc(10);
    check("scoreboard_drained", exp_byte_q.size() + exp_nack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
